// File: rtl/gp_regfile_pkg.sv
// Shared types and the write-op arithmetic for the general-purpose register file.
package gp_regfile_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_CLR  = 2'b11
   } wr_op_t;

   // Widest register this helper supports. Callers zero-extend their operands
   // and truncate the result back to their own width, so the wrap behaviour
   // of INC/DEC is exact modulo 2^WIDTH.
   localparam int MAX_WIDTH = 64;

   // Value a register takes after a write op. Used by both the write path and
   // the bypass path so they cannot disagree.
   function automatic logic [MAX_WIDTH-1:0] next_val(
      input wr_op_t                 op,
      input logic [MAX_WIDTH-1:0]   cur,
      input logic [MAX_WIDTH-1:0]   data
   );
      logic [MAX_WIDTH-1:0] res;
      res = '0;
      unique case (op)
         OP_LOAD: res = data;
         OP_INC:  res = cur + MAX_WIDTH'(1);
         OP_DEC:  res = cur - MAX_WIDTH'(1);
         OP_CLR:  res = '0;
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/gp_scoreboard.sv
// Per-register busy scoreboard: tracks pending writebacks so the sequencer can
// stall, and flags reservations of registers that are already pending.
module gp_scoreboard #(
   parameter int DEPTH    = 8,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_sel,
   input  logic                     rsv_en,
   input  logic [$clog2(DEPTH)-1:0] rsv_sel,
   input  logic [$clog2(DEPTH)-1:0] rd_a_sel,
   input  logic [$clog2(DEPTH)-1:0] rd_b_sel,
   output logic                     rd_a_busy,
   output logic                     rd_b_busy,
   output logic                     rsv_err
);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;
   logic             rsv_ok;
   logic             err_next;

   // Register 0 never becomes busy when it is hardwired to zero.
   assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_sel == '0));

   // Busy update: a writeback clears, a reservation sets, and set wins so a
   // register retired and re-reserved in one cycle stays pending.
   always_comb begin
      // NOTE: combinational blocks start from a full default so no path can
      // leave a bit unassigned and infer a latch; blocking '=' is used here
      // because later lines must see the earlier ones within the same pass.
      busy_next = busy;
      if (wr_en) busy_next[wr_sel] = 1'b0;
      if (rsv_ok) busy_next[rsv_sel] = 1'b1;
   end

   // A reservation of a pending register is an error unless that pending
   // write retires in the same cycle.
   assign err_next = rsv_ok && busy[rsv_sel] && !(wr_en && (wr_sel == rsv_sel));

   // Busy vector and error pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples
      // the pre-edge values regardless of statement order.
      if (!rst_n) begin
         busy    <= '0;
         rsv_err <= 1'b0;
      end else begin
         busy    <= busy_next;
         rsv_err <= err_next;
      end
   end

   // Busy seen by the read ports; a same-cycle writeback masks it when the
   // written value is being forwarded.
   always_comb begin
      rd_a_busy = busy[rd_a_sel] && !((BYPASS != 0) && wr_en && (wr_sel == rd_a_sel));
      rd_b_busy = busy[rd_b_sel] && !((BYPASS != 0) && wr_en && (wr_sel == rd_b_sel));
   end

endmodule

// File: rtl/gp_regfile.sv
// General-purpose register file: two asynchronous read ports, one write port
// with load/inc/dec/clear ops, optional write-to-read bypass and a busy
// scoreboard for pending writebacks.
module gp_regfile
   import gp_regfile_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_sel,
   input  wr_op_t                   wr_op,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_a_sel,
   output logic [WIDTH-1:0]         rd_a_data,
   output logic                     rd_a_busy,
   input  logic [$clog2(DEPTH)-1:0] rd_b_sel,
   output logic [WIDTH-1:0]         rd_b_data,
   output logic                     rd_b_busy,
   input  logic                     rsv_en,
   input  logic [$clog2(DEPTH)-1:0] rsv_sel,
   output logic                     rsv_err,
   output logic [WIDTH-1:0]         rega,
   output logic [WIDTH-1:0]         regb
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] wr_value;
   logic             wr_apply;
   logic             a_zero, a_byp;
   logic             b_zero, b_byp;

   // Next value of the write target, shared by storage and the bypass path.
   always_comb begin
      wr_value = WIDTH'(next_val(wr_op, MAX_WIDTH'(regs[wr_sel]), MAX_WIDTH'(wr_data)));
   end

   // Writes to a hardwired-zero register 0 are dropped.
   assign wr_apply = wr_en && !((ZERO_REG != 0) && (wr_sel == '0));

   // Register storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array is reset explicitly because every output must read
         // zero during reset; this keeps it in flops rather than a RAM macro.
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_apply) begin
         regs[wr_sel] <= wr_value;
      end
   end

   // Read-port selection: zero register first, then forwarding, then storage.
   always_comb begin
      a_zero    = (ZERO_REG != 0) && (rd_a_sel == '0);
      b_zero    = (ZERO_REG != 0) && (rd_b_sel == '0);
      a_byp     = (BYPASS != 0) && wr_en && (wr_sel == rd_a_sel);
      b_byp     = (BYPASS != 0) && wr_en && (wr_sel == rd_b_sel);
      rd_a_data = a_zero ? '0 : (a_byp ? wr_value : regs[rd_a_sel]);
      rd_b_data = b_zero ? '0 : (b_byp ? wr_value : regs[rd_b_sel]);
   end

   // Stored registers 0 and 1 for the ALU and debug, never forwarded.
   always_comb begin
      rega = (ZERO_REG != 0) ? '0 : regs[0];
      regb = regs[1];
   end

   gp_scoreboard #(
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .rsv_en    (rsv_en),
      .rsv_sel   (rsv_sel),
      .rd_a_sel  (rd_a_sel),
      .rd_b_sel  (rd_b_sel),
      .rd_a_busy (rd_a_busy),
      .rd_b_busy (rd_b_busy),
      .rsv_err   (rsv_err)
   );

endmodule

// File: tb/tb_gp_regfile.sv
// Directed bench for gp_regfile: a default instance (bypass on, no zero
// register) driven from a vector table, plus a second instance with bypass off
// and register 0 hardwired to zero sharing the same inputs.
module tb_gp_regfile;
   import gp_regfile_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [2:0] wr_sel;
   wr_op_t     wr_op;
   logic [7:0] wr_data;
   logic [2:0] rd_a_sel, rd_b_sel;
   logic       rsv_en;
   logic [2:0] rsv_sel;

   logic [7:0] m_rd_a, m_rd_b, m_rega, m_regb;
   logic       m_a_busy, m_b_busy, m_err;
   logic [7:0] z_rd_a, z_rd_b, z_rega, z_regb;
   logic       z_a_busy, z_b_busy, z_err;

   int total = 0;
   int bad   = 0;

   gp_regfile u_dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_op(wr_op),
      .wr_data(wr_data), .rd_a_sel(rd_a_sel), .rd_a_data(m_rd_a), .rd_a_busy(m_a_busy),
      .rd_b_sel(rd_b_sel), .rd_b_data(m_rd_b), .rd_b_busy(m_b_busy),
      .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_err(m_err), .rega(m_rega), .regb(m_regb)
   );

   gp_regfile #(.ZERO_REG(1), .BYPASS(0)) u_alt (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_op(wr_op),
      .wr_data(wr_data), .rd_a_sel(rd_a_sel), .rd_a_data(z_rd_a), .rd_a_busy(z_a_busy),
      .rd_b_sel(rd_b_sel), .rd_b_data(z_rd_b), .rd_b_busy(z_b_busy),
      .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_err(z_err), .rega(z_rega), .regb(z_regb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [2:0] ws;
      wr_op_t     op;
      logic [7:0] wd;
      logic [2:0] ra;
      logic [2:0] rb;
      logic       re;
      logic [2:0] rs;
      logic [7:0] ea;
      logic [7:0] eb;
      logic       eab;
      logic       ebb;
      logic [7:0] erga;
      logic [7:0] ergb;
      logic       eerr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [2:0] ws, input wr_op_t op,
                        input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb,
                        input logic re, input logic [2:0] rs);
      wr_en = we; wr_sel = ws; wr_op = op; wr_data = wd;
      rd_a_sel = ra; rd_b_sel = rb; rsv_en = re; rsv_sel = rs;
   endtask

   function automatic vec_t mk(input logic we, input logic [2:0] ws, input wr_op_t op,
                               input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb,
                               input logic re, input logic [2:0] rs,
                               input logic [7:0] ea, input logic [7:0] eb,
                               input logic eab, input logic ebb,
                               input logic [7:0] erga, input logic [7:0] ergb, input logic eerr);
      vec_t v;
      v.we = we; v.ws = ws; v.op = op; v.wd = wd; v.ra = ra; v.rb = rb; v.re = re; v.rs = rs;
      v.ea = ea; v.eb = eb; v.eab = eab; v.ebb = ebb; v.erga = erga; v.ergb = ergb; v.eerr = eerr;
      return v;
   endfunction

   initial begin
      // Expected values below are for the default instance (bypass on).
      //                we ws op       wd     ra rb re rs  ea     eb     ab bb rega   regb   err
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0)); // reset state
      vecs.push_back(mk(1, 0, OP_LOAD, 8'h11, 0, 1, 0, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00, 0)); // bypass, rega not
      vecs.push_back(mk(1, 1, OP_LOAD, 8'h22, 0, 1, 0, 0, 8'h11, 8'h22, 0, 0, 8'h11, 8'h00, 0));
      vecs.push_back(mk(1, 3, OP_LOAD, 8'h5C, 3, 3, 0, 0, 8'h5C, 8'h5C, 0, 0, 8'h11, 8'h22, 0)); // load+bypass
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 3, 2, 0, 0, 8'h5C, 8'h00, 0, 0, 8'h11, 8'h22, 0));
      vecs.push_back(mk(1, 2, OP_LOAD, 8'hFF, 2, 3, 0, 0, 8'hFF, 8'h5C, 0, 0, 8'h11, 8'h22, 0));
      vecs.push_back(mk(1, 2, OP_INC,  8'h00, 2, 2, 0, 0, 8'h00, 8'h00, 0, 0, 8'h11, 8'h22, 0)); // FF+1 wraps
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 2, 1, 0, 0, 8'h00, 8'h22, 0, 0, 8'h11, 8'h22, 0));
      vecs.push_back(mk(1, 2, OP_DEC,  8'h00, 2, 1, 0, 0, 8'hFF, 8'h22, 0, 0, 8'h11, 8'h22, 0)); // 00-1 wraps
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 2, 0, 0, 0, 8'hFF, 8'h11, 0, 0, 8'h11, 8'h22, 0));
      vecs.push_back(mk(1, 2, OP_CLR,  8'hAB, 2, 3, 0, 0, 8'h00, 8'h5C, 0, 0, 8'h11, 8'h22, 0)); // clr ignores data
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 2, 0, 0, 0, 8'h00, 8'h11, 0, 0, 8'h11, 8'h22, 0));
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 4, 4, 1, 4, 8'h00, 8'h00, 0, 0, 8'h11, 8'h22, 0)); // reserve 4
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 4, 4, 0, 0, 8'h00, 8'h00, 1, 1, 8'h11, 8'h22, 0));
      vecs.push_back(mk(1, 4, OP_LOAD, 8'h33, 5, 4, 0, 0, 8'h00, 8'h33, 0, 0, 8'h11, 8'h22, 0)); // busy masked
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 4, 4, 0, 0, 8'h33, 8'h33, 0, 0, 8'h11, 8'h22, 0));
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 4, 4, 1, 4, 8'h33, 8'h33, 0, 0, 8'h11, 8'h22, 0)); // reserve 4
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 4, 4, 1, 4, 8'h33, 8'h33, 1, 1, 8'h11, 8'h22, 0)); // again
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 4, 4, 0, 0, 8'h33, 8'h33, 1, 1, 8'h11, 8'h22, 1)); // err pulse
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 4, 4, 0, 0, 8'h33, 8'h33, 1, 1, 8'h11, 8'h22, 0)); // one cycle
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 5, 4, 1, 5, 8'h00, 8'h33, 0, 1, 8'h11, 8'h22, 0)); // reserve 5
      vecs.push_back(mk(1, 5, OP_LOAD, 8'h44, 5, 4, 1, 5, 8'h44, 8'h33, 0, 1, 8'h11, 8'h22, 0)); // rsv+wr 5
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 5, 4, 0, 0, 8'h44, 8'h33, 1, 1, 8'h11, 8'h22, 0)); // set wins
      vecs.push_back(mk(0, 0, OP_LOAD, 8'h00, 5, 4, 0, 0, 8'h44, 8'h33, 1, 1, 8'h11, 8'h22, 0)); // no err

      rst_n = 1'b0;
      drive(0, 0, OP_LOAD, 8'h00, 0, 1, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].we, vecs[i].ws, vecs[i].op, vecs[i].wd,
               vecs[i].ra, vecs[i].rb, vecs[i].re, vecs[i].rs);
         #1;
         check($sformatf("v%0d rd_a_data", i), 32'(m_rd_a),   32'(vecs[i].ea));
         check($sformatf("v%0d rd_b_data", i), 32'(m_rd_b),   32'(vecs[i].eb));
         check($sformatf("v%0d rd_a_busy", i), 32'(m_a_busy), 32'(vecs[i].eab));
         check($sformatf("v%0d rd_b_busy", i), 32'(m_b_busy), 32'(vecs[i].ebb));
         check($sformatf("v%0d rega", i),      32'(m_rega),   32'(vecs[i].erga));
         check($sformatf("v%0d regb", i),      32'(m_regb),   32'(vecs[i].ergb));
         check($sformatf("v%0d rsv_err", i),   32'(m_err),    32'(vecs[i].eerr));
      end

      // Bypass on versus off: same-cycle read of a register being loaded.
      @(negedge clk);
      drive(1, 6, OP_LOAD, 8'h5C, 6, 6, 0, 0);
      #1;
      check("bypass on same cycle", 32'(m_rd_a), 32'h5C);
      check("bypass off same cycle", 32'(z_rd_a), 32'h00);
      @(negedge clk);
      drive(0, 0, OP_LOAD, 8'h00, 6, 6, 0, 0);
      #1;
      check("bypass off after edge", 32'(z_rd_a), 32'h5C);
      check("bypass on after edge", 32'(m_rd_b), 32'h5C);

      // Hardwired zero register: load and reserve index 0.
      @(negedge clk);
      drive(1, 0, OP_LOAD, 8'h77, 0, 0, 1, 0);
      #1;
      check("zero reg rd_a same cycle", 32'(z_rd_a), 32'h00);
      check("zero reg rega same cycle", 32'(z_rega), 32'h00);
      check("zero reg busy same cycle", 32'(z_a_busy), 32'h0);
      check("normal reg0 bypass", 32'(m_rd_a), 32'h77);
      @(negedge clk);
      drive(0, 0, OP_LOAD, 8'h00, 0, 0, 0, 0);
      #1;
      check("zero reg rd_a after", 32'(z_rd_a), 32'h00);
      check("zero reg rega after", 32'(z_rega), 32'h00);
      check("zero reg busy after", 32'(z_a_busy), 32'h0);
      check("zero reg rsv_err", 32'(z_err), 32'h0);
      check("normal reg0 rega", 32'(m_rega), 32'h77);
      check("normal reg0 busy", 32'(m_a_busy), 32'h1);

      // Asynchronous reset mid-run with data, busy bits and an error pulse live.
      @(negedge clk);
      drive(1, 7, OP_LOAD, 8'hAA, 7, 4, 1, 4);
      @(negedge clk);
      drive(0, 0, OP_LOAD, 8'h00, 7, 4, 0, 0);
      #1;
      check("pre-reset rd_a", 32'(m_rd_a), 32'hAA);
      check("pre-reset rsv_err", 32'(m_err), 32'h1);
      check("pre-reset rd_b_busy", 32'(m_b_busy), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("reset rd_a", 32'(m_rd_a), 32'h00);
      check("reset rd_b", 32'(m_rd_b), 32'h00);
      check("reset rega", 32'(m_rega), 32'h00);
      check("reset regb", 32'(m_regb), 32'h00);
      check("reset rd_a_busy", 32'(m_a_busy), 32'h0);
      check("reset rd_b_busy", 32'(m_b_busy), 32'h0);
      check("reset rsv_err", 32'(m_err), 32'h0);
      check("reset alt rd_a", 32'(z_rd_a), 32'h00);
      check("reset alt regb", 32'(z_regb), 32'h00);

      // Writes resume once reset is released.
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive(1, 1, OP_LOAD, 8'h3C, 7, 1, 0, 0);
      @(negedge clk);
      drive(0, 0, OP_LOAD, 8'h00, 7, 1, 0, 0);
      #1;
      check("post-reset regb", 32'(m_regb), 32'h3C);
      check("post-reset reg7", 32'(m_rd_a), 32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
